// File: rtl/led_pattern_counter.sv
// led_pattern_counter: prescaled up/down/Gray/bounce LED counter with load and step/wrap pulses.
// Define LED_PATTERN_GRAY_EN to make mode 10 drive Gray-encoded LEDs; otherwise mode 10 counts in binary.
module led_pattern_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2**WIDTH,
  parameter int DIV     = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led_count,
  output logic             step,
  output logic             wrap
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   LIM  = (WIDTH+1)'(MODULUS);
  localparam logic [PW-1:0]    PTOP = PW'(DIV - 1);
  logic [WIDTH-1:0] r_cnt, w_stp, w_nxt, w_led;
  logic [PW-1:0]    r_pre;
  logic             r_dir, w_dir, w_wrap, w_tick;
  always_comb begin
    w_tick = en && (r_pre == PTOP);
    w_dir  = r_dir;
    w_wrap = r_cnt == TOP;
    w_stp  = w_wrap ? '0 : r_cnt + 1'b1;
    case (mode)
      2'b01: begin
        w_wrap = r_cnt == '0;
        w_stp  = w_wrap ? TOP : r_cnt - 1'b1;
      end
      2'b11: begin
        w_wrap = r_dir ? (r_cnt == '0) : (r_cnt == TOP);
        w_dir  = r_dir ^ w_wrap;
        w_stp  = r_dir ? (w_wrap ? WIDTH'(1) : r_cnt - 1'b1)
                       : (w_wrap ? TOP - 1'b1 : r_cnt + 1'b1);
      end
      default: ;
    endcase
    // out-of-range load values clamp to the top of the count range
    w_nxt = load ? (({1'b0, load_val} < LIM) ? load_val : TOP) : w_stp;
`ifdef LED_PATTERN_GRAY_EN
    w_led = (mode == 2'b10) ? w_nxt ^ (w_nxt >> 1) : w_nxt;
`else
    w_led = w_nxt;
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_pre     <= '0;
      r_dir     <= 1'b0;
      led_count <= '0;
      step      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      step <= !load && w_tick;
      wrap <= !load && w_tick && w_wrap;
      if (load || w_tick) begin
        r_cnt     <= w_nxt;
        led_count <= w_led;
        r_pre     <= '0;
        r_dir     <= !load && w_dir;
      end else if (en) begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_led_pattern_counter.sv
// tb_led_pattern_counter: three configurations driven in parallel and checked against an integer reference model.
module tb_led_pattern_counter;
  logic clk, reset_n, en, load;
  logic [1:0] mode;
  logic [3:0] lv;
  logic [2:0] led_a, led_c;
  logic [3:0] led_b;
  logic step_a, step_b, step_c, wrap_a, wrap_b, wrap_c;
  int checks = 0, errors = 0;
  int wd[3] = '{3, 4, 3};
  int md[3] = '{8, 10, 4};
  int dv[3] = '{1, 4, 1};
  int cnt[3], pre[3], dir[3], eled[3], estep[3], ewrap[3];
`ifdef LED_PATTERN_GRAY_EN
  localparam bit GRAY = 1'b1;
  int gseq[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
`else
  localparam bit GRAY = 1'b0;
  int gseq[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
`endif
  int bseq[7] = '{1, 2, 3, 2, 1, 0, 1};

  led_pattern_counter #(.WIDTH(3), .MODULUS(8), .DIV(1)) u_a (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .load(load), .load_val(lv[2:0]),
    .led_count(led_a), .step(step_a), .wrap(wrap_a));
  led_pattern_counter #(.WIDTH(4), .MODULUS(10), .DIV(4)) u_b (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .load(load), .load_val(lv),
    .led_count(led_b), .step(step_b), .wrap(wrap_b));
  led_pattern_counter #(.WIDTH(3), .MODULUS(4), .DIV(1)) u_c (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .load(load), .load_val(lv[2:0]),
    .led_count(led_c), .step(step_c), .wrap(wrap_c));

  always #5 clk = ~clk;

  function automatic int enc(input int v);
    return (GRAY && mode == 2'd2) ? (v ^ (v >> 1)) : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0; pre[i] = 0; dir[i] = 0; eled[i] = 0; estep[i] = 0; ewrap[i] = 0;
    end
  endtask

  task automatic model_step();
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      estep[i] = 0; ewrap[i] = 0;
      if (load) begin
        cnt[i] = int'(lv) % (1 << wd[i]);
        if (cnt[i] > md[i] - 1) cnt[i] = md[i] - 1;
        pre[i] = 0; dir[i] = 0; eled[i] = enc(cnt[i]);
      end else if (en) begin
        if (pre[i] < dv[i] - 1) pre[i]++;
        else begin
          pre[i] = 0; estep[i] = 1;
          if (mode == 2'd1) begin
            ewrap[i] = int'(cnt[i] == 0);
            cnt[i] = (cnt[i] + md[i] - 1) % md[i];
          end else if (mode == 2'd3) begin
            if (dir[i] == 0 && cnt[i] == md[i] - 1) begin cnt[i] = md[i] - 2; dir[i] = 1; ewrap[i] = 1; end
            else if (dir[i] == 1 && cnt[i] == 0) begin cnt[i] = 1; dir[i] = 0; ewrap[i] = 1; end
            else cnt[i] = dir[i] ? cnt[i] - 1 : cnt[i] + 1;
          end else begin
            ewrap[i] = int'(cnt[i] == md[i] - 1);
            cnt[i] = (cnt[i] + 1) % md[i];
          end
          eled[i] = enc(cnt[i]);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int ol[3], os[3], ow[3];
    ol = '{int'(led_a), int'(led_b), int'(led_c)};
    os = '{int'(step_a), int'(step_b), int'(step_c)};
    ow = '{int'(wrap_a), int'(wrap_b), int'(wrap_c)};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_led%0d", tag, i), ol[i], eled[i]);
      chk($sformatf("%s_step%0d", tag, i), os[i], estep[i]);
      chk($sformatf("%s_wrap%0d", tag, i), ow[i], ewrap[i]);
    end
  endtask

  task automatic cyc(input bit e, input bit [1:0] m, input bit l, input bit [3:0] v, input string tag);
    en = e; mode = m; load = l; lv = v;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    clk = 1'b0; reset_n = 1'b1; en = 1'b0; load = 1'b0; mode = 2'd0; lv = 4'd0;
    #1 reset_n = 1'b0;
    #1 model_reset();
    check_all("reset");
    cyc(1, 0, 0, 0, "rst_hold");
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 0, 0, "up");
      chk("up_seq_a", int'(led_a), (k + 1) % 8);
      chk("up_wrap_a", int'(wrap_a), int'(k == 7));
    end
    for (int k = 0; k < 7; k++) cyc(1, 1, 0, 0, "down");
    cyc(0, 3, 1, 0, "bld");
    for (int k = 0; k < 7; k++) begin
      cyc(1, 3, 0, 0, "bounce");
      chk("bounce_seq_c", int'(led_c), bseq[k]);
    end
    cyc(1, 3, 0, 0, "bounce");
    do_reset();
    for (int k = 0; k < 2; k++) begin
      cyc(1, 3, 0, 0, "post_rst");
      chk("post_rst_c", int'(led_c), k + 1);
    end
    cyc(0, 0, 1, 0, "div_ld");
    n = 0;
    while (!step_b && n < 20) begin cyc(1, 0, 0, 0, "div"); n++; end
    chk("div_first", n, 4);
    cyc(1, 0, 0, 0, "div"); cyc(0, 0, 0, 0, "div"); cyc(0, 0, 0, 0, "div");
    n = 3;
    while (!step_b && n < 20) begin cyc(1, 0, 0, 0, "div"); n++; end
    chk("div_gap", n, 6);
    cyc(0, 0, 1, 12, "clamp");
    chk("clamp_b", int'(led_b), 9);
    cyc(1, 0, 1, 3, "ld_en");
    chk("ld_en_b", int'(led_b), 3);
    chk("ld_en_step_b", int'(step_b), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 0, "ld_next");
      chk("ld_next_step_b", int'(step_b), int'(k == 3));
    end
    cyc(0, 2, 1, 0, "gld");
    for (int k = 0; k < 8; k++) begin
      cyc(1, 2, 0, 0, "gray");
      chk("gray_seq_a", int'(led_a), gseq[k]);
    end
    cyc(0, 0, 0, 0, "modechg");
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(99) < 2) do_reset();
      cyc($urandom_range(3) != 0, 2'($urandom_range(3)), $urandom_range(19) == 0, 4'($urandom_range(15)), "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
